// File: rtl/rx_timer_pkg.sv
// rx_timer_pkg: default bit-timing constants and the bit_count width helper
// shared by the RX bit timer and its phase counter.
package rx_timer_pkg;

    localparam int RX_CYCLES_PER_BIT = 8;
    localparam int RX_SAMPLE_POINT   = 3;
    localparam int RX_BITS_PER_BYTE  = 8;

    function automatic int rx_count_width(input int bits_per_byte);
        return $clog2(bits_per_byte + 1);
    endfunction

endpackage

// File: rtl/rx_phase_counter.sv
// rx_phase_counter: bit-phase counter wrapping at CYCLES-1, with synchronous
// clear, synchronous load-to-1 (clear wins) and asynchronous active-high reset.
module rx_phase_counter
    import rx_timer_pkg::*;
#(
    parameter int CYCLES = RX_CYCLES_PER_BIT,
    parameter int W      = $clog2(CYCLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load_one,
    output logic [W-1:0] phase
);

    logic [W-1:0] phase_d;
    logic [W-1:0] phase_q;

    always_comb begin
        phase_d = clr ? '0
                : load_one ? W'(1)
                : (phase_q == W'(CYCLES - 1)) ? '0
                : phase_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= '0;
        else     phase_q <= phase_d;
    end

    assign phase = phase_q;

endmodule

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: RX bit sampling strobe and byte framing counter.
// Define RX_TIMER_RESYNC_EN to let d_edge resynchronise the bit phase.
module rx_bit_timer
    import rx_timer_pkg::*;
#(
    parameter int CYCLES_PER_BIT = RX_CYCLES_PER_BIT,
    parameter int SAMPLE_POINT   = RX_SAMPLE_POINT,
    parameter int BITS_PER_BYTE  = RX_BITS_PER_BYTE,
    localparam int PW = $clog2(CYCLES_PER_BIT),
    localparam int CW = rx_count_width(BITS_PER_BYTE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable_timer,
    input  logic          d_edge,
    input  logic          stuff_bit,
    output logic          shift_enable,
    output logic          byte_received,
    output logic [CW-1:0] bit_count
);

    logic [PW-1:0] phase;
    logic          load_one;
    logic          count_bit;
    logic          last_bit;
    logic [CW-1:0] bit_count_d;
    logic [CW-1:0] bit_count_q;
    logic          byte_received_d;
    logic          byte_received_q;

`ifdef RX_TIMER_RESYNC_EN
    // The edge cycle becomes phase 0 of a new bit, so the next phase is 1.
    assign load_one = enable_timer && d_edge;
`else
    logic unused_d_edge;
    assign unused_d_edge = d_edge;
    assign load_one      = 1'b0;
`endif

    rx_phase_counter #(
        .CYCLES(CYCLES_PER_BIT),
        .W     (PW)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .clr     (!enable_timer),
        .load_one(load_one),
        .phase   (phase)
    );

    assign shift_enable = enable_timer && (phase == PW'(SAMPLE_POINT));
    assign count_bit    = shift_enable && !stuff_bit;
    assign last_bit     = bit_count_q == CW'(BITS_PER_BYTE - 1);

    always_comb begin
        bit_count_d     = !enable_timer ? '0
                        : !count_bit ? bit_count_q
                        : last_bit ? '0
                        : bit_count_q + CW'(1);
        byte_received_d = count_bit && last_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_count_q     <= '0;
            byte_received_q <= 1'b0;
        end else begin
            bit_count_q     <= bit_count_d;
            byte_received_q <= byte_received_d;
        end
    end

    assign bit_count     = bit_count_q;
    assign byte_received = byte_received_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: scoreboard bench; the model derives strobes from the cycle
// distance to the last phase anchor (enable start or resync edge).
module tb_rx_bit_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;
    localparam int BPB = 8;
`ifdef RX_TIMER_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_timer = 1'b0;
    logic       d_edge = 1'b0;
    logic       stuff_bit = 1'b0;
    logic       shift_enable;
    logic       byte_received;
    logic [3:0] bit_count;

    rx_bit_timer #(
        .CYCLES_PER_BIT(CPB),
        .SAMPLE_POINT  (SP),
        .BITS_PER_BYTE (BPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_timer (enable_timer),
        .d_edge       (d_edge),
        .stuff_bit    (stuff_bit),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic se;
        logic br;
        int   bc;
        int   t;
    } exp_t;

    exp_t exp_q[$];
    int   se_log[$];
    int   br_log[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   t      = 0;
    int   cyc    = 0;

    int   m_anchor = 0;
    int   m_cnt    = 0;
    logic m_br     = 1'b0;
    logic m_fresh  = 1'b1;

    function automatic void chk(input string name, input int t_at, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %0d, expected %0d", name, t_at, act, exp);
        end
    endfunction

    // Drive one cycle of stimulus and queue the model's expected outputs for it.
    task automatic step(input logic en, input logic ed, input logic st, input logic r);
        exp_t e;
        logic se_exp;
        @(posedge clk);
        #1;
        enable_timer = en;
        d_edge       = ed;
        stuff_bit    = st;
        rst          = r;
        if (r) begin
            e       = '{se: 1'b0, br: 1'b0, bc: 0, t: t};
            m_cnt   = 0;
            m_br    = 1'b0;
            m_fresh = 1'b1;
        end else begin
            if (en && m_fresh) m_anchor = cyc;
            se_exp = en && ((cyc - m_anchor) % CPB == SP);
            e = '{se: se_exp, br: m_br, bc: m_cnt, t: t};
            if (!en) begin
                m_cnt = 0;
                m_br  = 1'b0;
            end else if (se_exp && !st) begin
                m_br  = (m_cnt == BPB - 1);
                m_cnt = m_br ? 0 : m_cnt + 1;
            end else begin
                m_br = 1'b0;
            end
            if (en && ed && RESYNC) m_anchor = cyc;
            m_fresh = !en;
        end
        exp_q.push_back(e);
        cyc++;
        t++;
    endtask

    task automatic start_scenario();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        se_log.delete();
        br_log.delete();
        t = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("shift_enable", e.t, int'(shift_enable), int'(e.se));
                chk("byte_received", e.t, int'(byte_received), int'(e.br));
                chk("bit_count", e.t, int'(bit_count), e.bc);
                if (shift_enable) se_log.push_back(e.t);
                if (byte_received) br_log.push_back(e.t);
            end
        end
    end

    initial begin : stimulus
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);

        start_scenario();
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("free_br_count", t, br_log.size(), 1);
        chk("free_br_cycle", t, br_log.size() > 0 ? br_log[0] : -1, 60);
        chk("free_se_count", t, se_log.size(), 8);

        start_scenario();
        for (int i = 0; i < 72; i++) step(1'b1, 1'b0, t == 19, 1'b0);
        settle();
        chk("stuff_br_cycle", t, br_log.size() > 0 ? br_log[0] : -1, 68);

        start_scenario();
        for (int i = 0; i < 30; i++) step(1'b1, t == 6, 1'b0, 1'b0);
        settle();
        chk("edge6_se0", t, se_log.size() > 0 ? se_log[0] : -1, 3);
        chk("edge6_se1", t, se_log.size() > 1 ? se_log[1] : -1, RESYNC ? 9 : 11);
        chk("edge6_se2", t, se_log.size() > 2 ? se_log[2] : -1, RESYNC ? 17 : 19);
        chk("edge6_se3", t, se_log.size() > 3 ? se_log[3] : -1, RESYNC ? 25 : 27);

        start_scenario();
        for (int i = 0; i < 14; i++) step(1'b1, t == 3, 1'b0, 1'b0);
        settle();
        chk("edge3_se0", t, se_log.size() > 0 ? se_log[0] : -1, 3);
        chk("edge3_se1", t, se_log.size() > 1 ? se_log[1] : -1, RESYNC ? 6 : 11);

        start_scenario();
        for (int i = 0; i < 72; i++) step(1'b1, 1'b0, 1'b0, t == 30 || t == 31);
        settle();
        chk("rst_se_after", t, se_log.size() > 4 ? se_log[4] : -1, 35);
        chk("rst_no_br", t, br_log.size(), 0);

        start_scenario();
        for (int i = 0; i < 64; i++) step(t < 59, 1'b0, 1'b0, 1'b0);
        settle();
        chk("drop_no_br", t, br_log.size(), 0);
        chk("drop_se_count", t, se_log.size(), 7);

        start_scenario();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
        settle();
        settle();
        chk("queue_drained", t, exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_bit_timer.md
# rx_bit_timer

Receive-side bit-timing block for the CDL USB serial path; it is the counterpart of the transmit bit timer. It sits between the RX edge detector and the RX control FSM. While enabled, it tracks bit phase on the oversampled line, resynchronising to observed line edges. It issues a one-cycle `shift_enable` at the sampling point of each bit and a one-cycle `byte_received` after every 8 counted (non-stuffed) bits.

## Interface
- `CYCLES_PER_BIT`, default 8: system clocks per bit period; must be ≥ 4.
- `SAMPLE_POINT`, default 3: phase value at which the bit is sampled; must be < `CYCLES_PER_BIT`.
- `BITS_PER_BYTE`, default 8: counted bits per `byte_received`.
- `clk` input, 1: system clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `enable_timer` input, 1: level from the RX FSM; low holds the block cleared.
- `d_edge` input, 1: one-cycle pulse from the edge detector on a line transition.
- `stuff_bit` input, 1: qualifies the current `shift_enable`; high means the sampled bit is a stuffed bit and is not counted.
- `shift_enable` output, 1: one-cycle sample/shift strobe.
- `byte_received` output, 1: one-cycle pulse after `BITS_PER_BYTE` counted bits.
- `bit_count` output, $clog2(BITS_PER_BYTE+1): counted bits in the current byte.

## Operation
- Registers:
  - `phase`, $clog2(CYCLES_PER_BIT) bits.
  - `bit_count`.
  - `byte_received` flop.
- States (implicit in `enable_timer`):
  - CLEAR: `enable_timer` = 0. Next `phase` = 0, next `bit_count` = 0, next `byte_received` = 0.
  - RUN: `enable_timer` = 1. The first enabled cycle has `phase` = 0.
- Phase counting in RUN: `phase` increments each cycle and wraps from `CYCLES_PER_BIT-1` to 0.
- `shift_enable` = `enable_timer` && `phase` == `SAMPLE_POINT`. It is a combinational decode of registered state and `enable_timer` only.
- Resync (when `RX_TIMER_RESYNC_EN` is defined): `d_edge` in RUN forces next `phase` = 1, so the edge cycle is treated as phase 0 of a new bit. Resync has priority over the increment and over the wrap.
- Bit counting: on `shift_enable` && !`stuff_bit`, `bit_count` increments.
  - If `bit_count` == `BITS_PER_BYTE-1` at that increment, next `bit_count` = 0 and next `byte_received` = 1.
  - `byte_received` otherwise returns to 0 the following cycle.
- `stuff_bit` is ignored when `shift_enable` is low.

## Timing
- Reset values: `phase` 0, `bit_count` 0, `shift_enable` 0, `byte_received` 0.
- Asynchronous `rst` mid-byte discards the partial byte. After `rst` falls with `enable_timer` high, the first `shift_enable` is `SAMPLE_POINT` cycles later.
- `shift_enable` latency: `SAMPLE_POINT` cycles after entering RUN or after a resync edge. Steady-state period is `CYCLES_PER_BIT`.
- `byte_received` is registered: it asserts the cycle after the final counted `shift_enable`.
- Simultaneous events:
  - `d_edge` together with `shift_enable`: the strobe still fires this cycle and the resync applies next cycle.
  - `enable_timer` falling on a final-bit strobe: CLEAR wins and `byte_received` is not asserted.
- `d_edge` in CLEAR is ignored.

## Configuration
- Macro: `RX_TIMER_RESYNC_EN`.
- Defined: `d_edge` resynchronises `phase` as described in Operation.
- Undefined: `d_edge` is unused (tied off internally). `phase` free-runs from enable, which suits clock-recovered or simulation-only paths.

## Structure
- Package `rx_timer_pkg` holds:
  - The default constants `RX_CYCLES_PER_BIT` (8), `RX_SAMPLE_POINT` (3) and `RX_BITS_PER_BYTE` (8).
  - A function computing the `bit_count` width.
- Sub-module `rx_phase_counter`: a wrapping phase counter with synchronous clear, synchronous load-to-1, and active-high asynchronous reset. Bit counting and pulse logic stay in the top module.

## Test plan
Default parameters, macro defined unless noted; cycle 0 is the first cycle with `enable_timer` high.
- Free run, no edges or stuffing: `shift_enable` at cycles 3, 11, …, 59. `byte_received` high only at cycle 60, and `bit_count` = 0 at cycle 60.
- `stuff_bit` high at the cycle-19 strobe: `bit_count` holds at 2 through cycle 26. `byte_received` moves to cycle 68.
- `d_edge` at cycle 6: `shift_enable` at cycle 9, then 17, 25. With the macro undefined, the same stimulus gives 3, 11, 19.
- `d_edge` at cycle 3, coincident with the strobe: `shift_enable` fires at cycle 3 and next at cycle 6.
- `rst` pulsed at cycle 30, `enable_timer` held high: all outputs and `bit_count` are 0 during reset. The first `shift_enable` comes 3 cycles after reset release, and the partial byte yields no `byte_received`.
- `enable_timer` dropped at cycle 59 (the 8th strobe): no `byte_received`. `bit_count` = 0 at cycle 60.
